// File: rtl/lcd_video_pkg.sv
// ---------------------------------------------------------------------------
// lcd_video_pkg
// Shared definitions for the LCD display path: the power sequencer state
// type and the default video timing constants used by video_position_sync.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_video_pkg;

    // Power sequencer states.
    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PWR_UP    = 3'd1,
        ST_SYNC_WAIT = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_PWR_DOWN  = 3'd5
    } pwr_state_e;

    // Default raster totals of video_position_sync.
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_TOTAL      = 525;
    localparam int unsigned FRAME_CYCLES = H_TOTAL * V_TOTAL;

    // Frame-gap timeout: 10/7 of a frame period (600000 cycles at the default
    // raster), enough slack that a healthy generator never trips it.
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = (FRAME_CYCLES * 10) / 7;

endpackage

// File: rtl/lcd_power_sequencer_frame_edge_counter.sv
// ---------------------------------------------------------------------------
// frame_edge_counter
// Detects the falling edge of v_blank (frame edge), counts frame edges and
// measures the gap in cycles since the last frame edge. Both counters
// saturate and are zeroed by i_clear.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_v_blank      : v_blank from the sync generator
//   i_clear        : synchronous clear of frame count and gap counter
//   o_frames       : frame edges seen since the last clear
//   o_timeout      : gap counter has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module frame_edge_counter
    import lcd_video_pkg::*;
#(
    parameter  int unsigned MAX_FRAMES     = 10,
    parameter  int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    localparam int unsigned FRM_W          = $clog2(MAX_FRAMES + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_v_blank,
    input  logic             i_clear,
    output logic [FRM_W-1:0] o_frames,
    output logic             o_timeout
);

    localparam int unsigned      GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FRM_W-1:0] FRM_SAT = FRM_W'(MAX_FRAMES);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(TIMEOUT_CYCLES);

    logic             r_v_blank_d;
    logic [FRM_W-1:0] r_frames;
    logic [GAP_W-1:0] r_gap;
    logic             w_fe;

    // Frame edge is the falling edge of v_blank.
    assign w_fe = r_v_blank_d & ~i_v_blank;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v_blank_d <= 1'b0;
            r_frames    <= '0;
            r_gap       <= '0;
        end else begin
            r_v_blank_d <= i_v_blank;
            if (i_clear) begin
                r_frames <= '0;
                r_gap    <= '0;
            end else if (w_fe) begin
                r_gap <= '0;
                if (r_frames != FRM_SAT) begin
                    r_frames <= r_frames + FRM_W'(1);
                end
            end else if (r_gap != GAP_SAT) begin
                r_gap <= r_gap + GAP_W'(1);
            end
        end
    end

    assign o_frames  = r_frames;
    assign o_timeout = (r_gap == GAP_SAT);

endmodule

// File: rtl/lcd_power_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_power_sequencer
// Orders LCD panel power, sync generator enable and backlight on power-up and
// power-down, using cycle delays around panel power and frame counts around
// the backlight. A stalled sync generator (no frame edge within
// TIMEOUT_CYCLES while frames are being counted) sets a sticky fault and
// forces an immediate power-down.
// Ports:
//   disp_clk     : pixel clock, the only clock
//   rst_n        : asynchronous active-low reset
//   power_req    : level request, 1 = display on
//   v_blank      : from the sync generator
//   sync_en      : sync generator enable
//   panel_pwr    : panel supply enable
//   backlight_en : backlight enable
//   ready        : high only while the display is fully on
//   fault        : sticky frame-timeout flag, cleared on the next power-up
// ---------------------------------------------------------------------------
module lcd_power_sequencer
    import lcd_video_pkg::*;
#(
    parameter int unsigned PWR_ON_CYCLES  = 2048,
    parameter int unsigned BL_ON_FRAMES   = 10,
    parameter int unsigned BL_OFF_FRAMES  = 2,
    parameter int unsigned PWR_OFF_CYCLES = 2048,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic disp_clk,
    input  logic rst_n,
    input  logic power_req,
    input  logic v_blank,
    output logic sync_en,
    output logic panel_pwr,
    output logic backlight_en,
    output logic ready,
    output logic fault
);

    // One cycle counter serves both PWR_UP and PWR_DOWN, one frame counter
    // serves both SYNC_WAIT and DRAIN; each is sized for the larger limit.
    localparam int unsigned MAX_CYC = (PWR_ON_CYCLES > PWR_OFF_CYCLES) ? PWR_ON_CYCLES : PWR_OFF_CYCLES;
    localparam int unsigned MAX_FRM = (BL_ON_FRAMES > BL_OFF_FRAMES) ? BL_ON_FRAMES : BL_OFF_FRAMES;
    localparam int unsigned CYC_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned FRM_W   = $clog2(MAX_FRM + 1);

    localparam logic [CYC_W-1:0] CYC_SAT = CYC_W'(MAX_CYC);
    localparam logic [CYC_W-1:0] CYC_ON  = CYC_W'(PWR_ON_CYCLES);
    localparam logic [CYC_W-1:0] CYC_OFF = CYC_W'(PWR_OFF_CYCLES);
    localparam logic [FRM_W-1:0] FRM_ON  = FRM_W'(BL_ON_FRAMES);
    localparam logic [FRM_W-1:0] FRM_OFF = FRM_W'(BL_OFF_FRAMES);

    pwr_state_e       r_state;
    logic [CYC_W-1:0] r_cyc;
    logic             r_sync_en;
    logic             r_panel_pwr;
    logic             r_backlight_en;
    logic             r_ready;
    logic             r_fault;

    logic [CYC_W-1:0] w_cyc_inc;
    logic             w_cyc_on_done;
    logic             w_cyc_off_done;
    logic [FRM_W-1:0] w_frames;
    logic [FRM_W-1:0] w_frm_target;
    logic             w_frm_done;
    logic             w_timeout;
    logic             w_counting;
    logic             w_leave;
    logic             w_fec_clear;

    // The count is compared after the increment, so the transition edge is
    // exactly PWR_ON/PWR_OFF cycles after the edge that entered the state.
    assign w_cyc_inc      = (r_cyc == CYC_SAT) ? r_cyc : r_cyc + CYC_W'(1);
    assign w_cyc_on_done  = (w_cyc_inc >= CYC_ON);
    assign w_cyc_off_done = (w_cyc_inc >= CYC_OFF);

    assign w_frm_target = (r_state == ST_SYNC_WAIT) ? FRM_ON : FRM_OFF;
    assign w_frm_done   = (w_frames >= w_frm_target);

    // The frame counter is held clear outside the frame-counting states and
    // cleared on the edge that leaves one, so every entry starts from zero.
    assign w_counting  = (r_state == ST_SYNC_WAIT) || (r_state == ST_DRAIN);
    assign w_leave     = w_timeout || w_frm_done || ((r_state == ST_SYNC_WAIT) && !power_req);
    assign w_fec_clear = !w_counting || w_leave;

    frame_edge_counter #(
        .MAX_FRAMES     (MAX_FRM),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_edge_counter (
        .i_clk     (disp_clk),
        .i_rst_n   (rst_n),
        .i_v_blank (v_blank),
        .i_clear   (w_fec_clear),
        .o_frames  (w_frames),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge disp_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_OFF;
            r_cyc          <= '0;
            r_sync_en      <= 1'b0;
            r_panel_pwr    <= 1'b0;
            r_backlight_en <= 1'b0;
            r_ready        <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (power_req) begin
                        r_state     <= ST_PWR_UP;
                        r_cyc       <= '0;
                        r_panel_pwr <= 1'b1;
                        r_fault     <= 1'b0;
                    end
                end
                ST_PWR_UP: begin
                    if (!power_req) begin
                        r_state <= ST_PWR_DOWN;
                        r_cyc   <= '0;
                    end else if (w_cyc_on_done) begin
                        r_state   <= ST_SYNC_WAIT;
                        r_cyc     <= '0;
                        r_sync_en <= 1'b1;
                    end else begin
                        r_cyc <= w_cyc_inc;
                    end
                end
                ST_SYNC_WAIT: begin
                    // Timeout wins over both the request drop and the final
                    // frame; a request drop wins over the final frame.
                    if (w_timeout) begin
                        r_state        <= ST_PWR_DOWN;
                        r_cyc          <= '0;
                        r_fault        <= 1'b1;
                        r_sync_en      <= 1'b0;
                        r_backlight_en <= 1'b0;
                        r_ready        <= 1'b0;
                    end else if (!power_req) begin
                        r_state <= ST_DRAIN;
                    end else if (w_frm_done) begin
                        r_state        <= ST_ACTIVE;
                        r_backlight_en <= 1'b1;
                        r_ready        <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!power_req) begin
                        r_state        <= ST_DRAIN;
                        r_backlight_en <= 1'b0;
                        r_ready        <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (w_timeout) begin
                        r_state        <= ST_PWR_DOWN;
                        r_cyc          <= '0;
                        r_fault        <= 1'b1;
                        r_sync_en      <= 1'b0;
                        r_backlight_en <= 1'b0;
                        r_ready        <= 1'b0;
                    end else if (w_frm_done) begin
                        r_state   <= ST_PWR_DOWN;
                        r_cyc     <= '0;
                        r_sync_en <= 1'b0;
                    end
                end
                ST_PWR_DOWN: begin
                    if (w_cyc_off_done) begin
                        r_state     <= ST_OFF;
                        r_cyc       <= '0;
                        r_panel_pwr <= 1'b0;
                    end else begin
                        r_cyc <= w_cyc_inc;
                    end
                end
                default: begin
                    r_state        <= ST_OFF;
                    r_cyc          <= '0;
                    r_sync_en      <= 1'b0;
                    r_panel_pwr    <= 1'b0;
                    r_backlight_en <= 1'b0;
                    r_ready        <= 1'b0;
                end
            endcase
        end
    end

    assign sync_en      = r_sync_en;
    assign panel_pwr    = r_panel_pwr;
    assign backlight_en = r_backlight_en;
    assign ready        = r_ready;
    assign fault        = r_fault;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_power_sequencer
// Self-checking bench: a vector table, hand-written corner sequences and a
// randomized run, all compared every cycle against a timeline model that
// derives the expected outputs from the sequencing rules.
// ---------------------------------------------------------------------------
module tb_lcd_power_sequencer;

    localparam int P_ON      = 4;
    localparam int F_ON      = 2;
    localparam int F_OFF     = 1;
    localparam int P_OFF     = 3;
    localparam int TO        = 50;
    localparam int VB_PERIOD = 20;

    logic disp_clk  = 1'b0;
    logic rst_n     = 1'b0;
    logic power_req = 1'b0;
    logic v_blank   = 1'b0;
    logic sync_en, panel_pwr, backlight_en, ready, fault;

    lcd_power_sequencer #(
        .PWR_ON_CYCLES  (P_ON),
        .BL_ON_FRAMES   (F_ON),
        .BL_OFF_FRAMES  (F_OFF),
        .PWR_OFF_CYCLES (P_OFF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .disp_clk     (disp_clk),
        .rst_n        (rst_n),
        .power_req    (power_req),
        .v_blank      (v_blank),
        .sync_en      (sync_en),
        .panel_pwr    (panel_pwr),
        .backlight_en (backlight_en),
        .ready        (ready),
        .fault        (fault)
    );

    always #5 disp_clk = ~disp_clk;

    int total = 0;
    int bad   = 0;
    int vb_ph = 0;

    // Timeline model: outputs plus direction of travel; phase is implied by
    // which outputs are on. Times are absolute edge numbers.
    bit m_pwr, m_sync, m_bl, m_rdy, m_fault, m_up, m_vbd;
    int cyc, m_t0, m_tref, m_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_pwr, m_sync, m_bl, m_rdy, m_fault, m_up, m_vbd} = '0;
        m_t0 = cyc; m_tref = cyc; m_frames = 0;
    endtask

    task automatic model_enter();
        m_t0 = cyc; m_tref = cyc; m_frames = 0;
    endtask

    task automatic model_edge(input bit pr, input bit vb);
        bit fe;
        fe = m_vbd & ~vb;
        m_vbd = vb;
        cyc++;
        if (!m_pwr) begin
            if (pr) begin m_pwr = 1; m_fault = 0; m_up = 1; model_enter(); end
        end else if (!m_sync && m_up) begin
            if (!pr) begin m_up = 0; model_enter(); end
            else if (cyc - m_t0 >= P_ON) begin m_sync = 1; model_enter(); end
        end else if (!m_sync) begin
            if (cyc - m_t0 >= P_OFF) begin m_pwr = 0; model_enter(); end
        end else if (m_bl) begin
            if (!pr) begin m_bl = 0; m_rdy = 0; m_up = 0; model_enter(); end
        end else begin
            // Frame-counting phases: an edge is visible one cycle after it
            // occurs; the gap is measured from entry or the last edge.
            if (cyc - m_tref > TO) begin
                m_fault = 1; m_sync = 0; m_up = 0; model_enter();
            end else if (m_up && !pr) begin
                m_up = 0; model_enter();
            end else if (m_frames >= (m_up ? F_ON : F_OFF)) begin
                if (m_up) begin m_bl = 1; m_rdy = 1; end
                else m_sync = 0;
                model_enter();
            end else if (fe) begin
                m_frames++; m_tref = cyc;
            end
        end
    endtask

    function automatic logic [4:0] dut_outs();
        return {panel_pwr, sync_en, backlight_en, ready, fault};
    endfunction

    function automatic logic [4:0] model_outs();
        return {m_pwr, m_sync, m_bl, m_rdy, m_fault};
    endfunction

    task automatic step(input bit pr, input bit vb);
        power_req = pr;
        v_blank   = vb;
        @(posedge disp_clk);
        model_edge(pr, vb);
        @(negedge disp_clk);
        chk("cycle_outputs", dut_outs(), model_outs());
        chk("invariant", (backlight_en & ~sync_en) | (sync_en & ~panel_pwr), 0);
    endtask

    task automatic stepf(input bit pr);
        bit vb;
        vb = ((vb_ph % VB_PERIOD) < (VB_PERIOD / 2));
        vb_ph++;
        step(pr, vb);
    endtask

    typedef struct {
        bit         pr;
        int         n;
        logic [4:0] exp;   // {panel_pwr, sync_en, backlight_en, ready, fault}
    } vec_t;

    vec_t vecs[$];

    initial begin
        int  n;
        bit  hold;
        bit  seen_bl;

        // Full power-up / power-down, then abort in PWR_UP at cycle 2.
        vecs.push_back('{1'b0,  3, 5'b00000});
        vecs.push_back('{1'b1,  1, 5'b10000});
        vecs.push_back('{1'b1,  3, 5'b10000});
        vecs.push_back('{1'b1,  1, 5'b11000});
        vecs.push_back('{1'b1, 41, 5'b11110});
        vecs.push_back('{1'b0,  1, 5'b11000});
        vecs.push_back('{1'b0, 24, 5'b00000});
        vecs.push_back('{1'b1,  1, 5'b10000});
        vecs.push_back('{1'b1,  1, 5'b10000});
        vecs.push_back('{1'b0,  1, 5'b10000});
        vecs.push_back('{1'b0,  2, 5'b10000});
        vecs.push_back('{1'b0,  1, 5'b00000});
        vecs.push_back('{1'b0,  2, 5'b00000});

        cyc = 0;
        model_reset();
        #12;
        chk("reset_panel_pwr", panel_pwr, 0);
        chk("reset_sync_en", sync_en, 0);
        chk("reset_backlight_en", backlight_en, 0);
        chk("reset_ready", ready, 0);
        chk("reset_fault", fault, 0);
        @(negedge disp_clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) stepf(vecs[i].pr);
            chk($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
        end

        // Timeout: v_blank frozen from the moment sync_en rises.
        n = 0;
        while (!sync_en && n < 20) begin stepf(1'b1); n++; end
        chk("to_sync_up", sync_en, 1);
        hold = v_blank;
        n = 0;
        while (!fault && n < 100) begin step(1'b1, hold); n++; end
        chk("to_latency", n, TO + 1);
        chk("to_sync_off", sync_en, 0);
        chk("to_panel_on", panel_pwr, 1);
        n = 0;
        while (panel_pwr && n < 20) begin step(1'b0, hold); n++; end
        chk("to_panel_off_delay", n, P_OFF);
        step(1'b0, hold);
        step(1'b0, hold);
        chk("to_fault_sticky", fault, 1);
        step(1'b1, hold);
        chk("to_fault_cleared", fault, 0);
        chk("to_restart_panel", panel_pwr, 1);

        // Simultaneous request drop and final frame edge in SYNC_WAIT.
        n = 0;
        while (!sync_en && n < 20) begin step(1'b1, 1'b1); n++; end
        chk("sim_sync_up", sync_en, 1);
        for (int k = 0; k < 3; k++)  step(1'b1, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("sim_still_sync", sync_en, 1);
        seen_bl = 1'b0;
        for (int k = 0; k < 30; k++) begin
            stepf(1'b0);
            if (backlight_en || ready) seen_bl = 1'b1;
        end
        chk("sim_no_backlight", seen_bl, 0);
        chk("sim_all_off", dut_outs(), 5'b00000);

        // Asynchronous reset mid-ACTIVE.
        n = 0;
        while (!backlight_en && n < 100) begin stepf(1'b1); n++; end
        chk("rst_active", {backlight_en, ready}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", dut_outs(), 5'b00000);
        model_reset();
        @(negedge disp_clk);
        rst_n = 1'b1;
        stepf(1'b1);
        chk("rst_restart_panel", panel_pwr, 1);
        n = 0;
        while (!sync_en && n < 20) begin stepf(1'b1); n++; end
        chk("rst_restart_sync_delay", n, P_ON);

        // Randomized request toggling and occasional frozen v_blank.
        begin
            bit pr = 1'b1;
            bit hv = 1'b0;
            int hold_left = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 39) == 0) pr = ~pr;
                if (hold_left == 0 && $urandom_range(0, 199) == 0) begin
                    hold_left = $urandom_range(30, 90);
                    hv = v_blank;
                end
                if (hold_left > 0) begin
                    hold_left--;
                    step(pr, hv);
                end else begin
                    stepf(pr);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
